// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_sched_pkg
// Brief   : Opcode constants, FSM state type and per-opcode latency helpers
//           shared by the ALU scheduler and its arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // True for the thirteen opcodes the ALU understands.
    function automatic logic op_is_legal(input logic [4:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Ops whose result carries meaningful upper 32 bits.
    function automatic logic op_is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // ALU settle cycles for an opcode.
    function automatic logic [3:0] op_latency(input logic [4:0] op,
                                              input logic [3:0] mul_lat,
                                              input logic [3:0] div_lat);
        logic [3:0] lat;
        lat = 4'd1;
        if (op == OP_MUL) begin
            lat = mul_lat;
        end else if (op == OP_DIV) begin
            lat = div_lat;
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way arbiter. With ALU_SCHED_RR_EN defined, ties go to the
//           requester not served most recently (pointer starts at 0);
//           otherwise requester 0 has fixed priority and no state exists.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

`ifdef ALU_SCHED_RR_EN
    // Index of the requester favoured on a tie.
    logic prio_q;
    logic prio_d;

    // Grant: single requester always wins, ties resolved by the pointer.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves to the other requester after every accept.
    always_comb begin
        prio_d = prio_q;
        if (update) begin
            prio_d = grant[0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    logic w_unused;

    // Fixed priority: requester 0 always wins.
    always_comb begin
        grant    = {req[1] & ~req[0], req[0]};
        w_unused = clk ^ clr ^ update;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : alu_scheduler
// Brief   : Shares one multi-cycle ALU between two requesters. Accepts one
//           operation at a time, drives the ALU for its latency, captures the
//           result and holds a response until consumed. Illegal ops and
//           divide-by-zero are answered with an error without using the ALU.
//           Arbitration policy selected by macro ALU_SCHED_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        busy
);

    localparam logic [3:0] C_MUL_LAT = 4'(MUL_LAT);
    localparam logic [3:0] C_DIV_LAT = 4'(DIV_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;

    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_sel;
    logic [31:0] w_sel_a, w_sel_b;
    logic [4:0]  w_sel_op;
    logic        w_fault;

    rr_arb2 u_arb (
        .clk    (clk),
        .clr    (clr),
        .req    ({req1_valid, req0_valid}),
        .update (w_accept),
        .grant  (w_grant)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: faults skip the ALU and go straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = w_fault ? S_RESP : S_EXEC;
            S_EXEC:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshakes, ALU drive and status.
    always_comb begin
        req0_ready = (state_q == S_IDLE) & w_grant[0] & ~clr;
        req1_ready = (state_q == S_IDLE) & w_grant[1] & ~clr;
        alu_a      = (state_q == S_EXEC) ? a_q  : 32'd0;
        alu_b      = (state_q == S_EXEC) ? b_q  : 32'd0;
        alu_op     = (state_q == S_EXEC) ? op_q : OP_NOP;
        busy       = (state_q != S_IDLE);
        rsp_valid  = rsp_valid_q;
        rsp_id     = rsp_id_q;
        rsp_err    = rsp_err_q;
        rsp_hi     = rsp_hi_q;
        rsp_lo     = rsp_lo_q;
    end

    // Accept detection and payload mux for the winning requester.
    always_comb begin
        w_accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        w_sel    = req1_ready;
        w_sel_a  = w_sel ? req1_a  : req0_a;
        w_sel_b  = w_sel ? req1_b  : req0_b;
        w_sel_op = w_sel ? req1_op : req0_op;
        w_fault  = ~op_is_legal(w_sel_op) | ((w_sel_op == OP_DIV) & (w_sel_b == 32'd0));
    end

    // Datapath: capture request, count ALU cycles, capture result. EXEC lasts
    // LAT cycles (counter loaded with LAT-1); rsp_valid follows one cycle
    // after RESP is entered.
    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    a_d  = w_sel_a;
                    b_d  = w_sel_b;
                    op_d = w_sel_op;
                    id_d = w_sel;
                    if (w_fault) begin
                        cnt_d     = 4'd0;
                        rsp_id_d  = w_sel;
                        rsp_err_d = 1'b1;
                        rsp_hi_d  = 32'd0;
                        rsp_lo_d  = 32'd0;
                    end else begin
                        cnt_d = op_latency(w_sel_op, C_MUL_LAT, C_DIV_LAT) - 4'd1;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_id_d  = id_q;
                    rsp_err_d = 1'b0;
                    rsp_hi_d  = op_is_wide(op_q) ? alu_c[63:32] : 32'd0;
                    rsp_lo_d  = alu_c[31:0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_d = ~(rsp_valid_q & rsp_ready);
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q       <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= OP_NOP;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_hi_q    <= 32'd0;
            rsp_lo_q    <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_scheduler
// Brief   : Randomised scoreboard bench for alu_scheduler with a behavioural
//           ALU and reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
`ifdef ALU_SCHED_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam int INT_BIG = 32'h7fff_ffff;

    localparam logic [4:0] T_ADD  = 5'b00011;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_AND  = 5'b00101;
    localparam logic [4:0] T_OR   = 5'b00110;
    localparam logic [4:0] T_SHR  = 5'b00111;
    localparam logic [4:0] T_SHRA = 5'b01000;
    localparam logic [4:0] T_SHL  = 5'b01001;
    localparam logic [4:0] T_ROR  = 5'b01010;
    localparam logic [4:0] T_ROL  = 5'b01011;
    localparam logic [4:0] T_MUL  = 5'b01111;
    localparam logic [4:0] T_DIV  = 5'b10000;
    localparam logic [4:0] T_NEG  = 5'b10001;
    localparam logic [4:0] T_NOT  = 5'b10010;

    logic [4:0] legal_ops [13] = '{T_ADD, T_SUB, T_AND, T_OR, T_SHR, T_SHRA, T_SHL,
                                   T_ROR, T_ROL, T_MUL, T_DIV, T_NEG, T_NOT};

    logic        clk, clr;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_c;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_hi, rsp_lo;

    alu_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; upper word is junk for narrow ops so masking is visible.
    function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
        logic [31:0] junk;
        int unsigned s;
        junk = a ^ 32'h5A5A_5A5A;
        s = b[4:0];
        case (op)
            T_ADD:   return {junk, a + b};
            T_SUB:   return {junk, a - b};
            T_AND:   return {junk, a & b};
            T_OR:    return {junk, a | b};
            T_SHR:   return {junk, a >> s};
            T_SHRA:  return {junk, 32'($signed(a) >>> s)};
            T_SHL:   return {junk, a << s};
            T_ROR:   return {junk, (a >> s) | (a << (32 - s))};
            T_ROL:   return {junk, (a << s) | (a >> (32 - s))};
            T_MUL:   return 64'(a) * 64'(b);
            T_DIV:   return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            T_NEG:   return {junk, 32'd0 - a};
            T_NOT:   return {junk, ~a};
            default: return {junk, junk};
        endcase
    endfunction

    assign alu_c = alu_fn(alu_a, alu_b, alu_op);

    function automatic bit is_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] hi, lo, a, b;
        logic [4:0]  op;
        int          lat;
        int          due;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
    } txn_t;

    exp_t sb[$];
    txn_t dir_q0[$], dir_q1[$];
    exp_t cur;

    int checks = 0, failures = 0;
    int idle_from = 0;
    int last_served = 1;
    bit started = 1'b0, stop_traffic = 1'b0, force_stall = 1'b0, in_rsp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected response from the operation's semantics; due = negedge cycle
    // index at which rsp_valid is first seen for an accept one edge ahead.
    function automatic exp_t make_exp(input logic id, input txn_t t, input int now);
        exp_t e;
        logic [63:0] c;
        e.id = id; e.op = t.op; e.a = t.a; e.b = t.b;
        e.err = !is_legal(t.op) || (t.op == T_DIV && t.b == 32'd0);
        if (e.err) begin
            e.hi = 32'd0; e.lo = 32'd0; e.lat = 0;
        end else begin
            c = alu_fn(t.a, t.b, t.op);
            e.lat = (t.op == T_MUL) ? MUL_LAT : (t.op == T_DIV) ? DIV_LAT : 1;
            e.hi = (t.op == T_MUL || t.op == T_DIV) ? c[63:32] : 32'd0;
            e.lo = c[31:0];
        end
        e.due = now + 2 + e.lat;
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int r;
        r = $urandom_range(0, 15);
        t.a = $urandom;
        t.b = $urandom;
        if (r < 13) begin
            t.op = legal_ops[r];
        end else if (r == 13) begin
            t.op = T_DIV; t.b = 32'd0;
        end else if (r == 14) begin
            do t.op = 5'($urandom_range(0, 31)); while (is_legal(t.op));
        end else begin
            t.op = T_DIV; t.b = $urandom_range(1, 9);
        end
        return t;
    endfunction

    // Requester driver: holds payload until accepted, checks grants.
    initial begin : driver
        bit acc0, acc1, idle;
        txn_t t;
        logic [1:0] exp_rdy;
        acc0 = 1'b0; acc1 = 1'b0;
        wait (started);
        forever begin
            @(negedge clk); #2;
            if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
            if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
            if (!req0_valid && (dir_q0.size() > 0 || (!stop_traffic && $urandom_range(0, 2) != 0))) begin
                if (dir_q0.size() > 0) t = dir_q0.pop_front(); else t = rand_txn();
                req0_op = t.op; req0_a = t.a; req0_b = t.b; req0_valid = 1'b1;
            end
            if (!req1_valid && (dir_q1.size() > 0 || (!stop_traffic && $urandom_range(0, 2) != 0))) begin
                if (dir_q1.size() > 0) t = dir_q1.pop_front(); else t = rand_txn();
                req1_op = t.op; req1_a = t.a; req1_b = t.b; req1_valid = 1'b1;
            end
            #1;
            if (!clr) begin
                idle = (cyc >= idle_from);
                if (!idle) exp_rdy = 2'b00;
                else if (req0_valid && req1_valid) exp_rdy = (RR_MODE && last_served == 0) ? 2'b10 : 2'b01;
                else exp_rdy = {req1_valid, req0_valid};
                check("req_ready", {req1_ready, req0_ready}, exp_rdy);
                if (req0_valid && req0_ready) begin
                    t.op = req0_op; t.a = req0_a; t.b = req0_b;
                    sb.push_back(make_exp(1'b0, t, cyc));
                    acc0 = 1'b1; last_served = 0; idle_from = INT_BIG;
                end else if (req1_valid && req1_ready) begin
                    t.op = req1_op; t.a = req1_a; t.b = req1_b;
                    sb.push_back(make_exp(1'b1, t, cyc));
                    acc1 = 1'b1; last_served = 1; idle_from = INT_BIG;
                end
            end
        end
    end

    // Monitor/consumer: ALU drive window, response latency and contents.
    initial begin : monitor
        exp_t e;
        bit in_exec;
        wait (started);
        forever begin
            @(negedge clk); #1;
            if (!clr) begin
                in_exec = 1'b0;
                if (sb.size() > 0) begin
                    e = sb[0];
                    in_exec = !e.err && (cyc >= e.due - 1 - e.lat) && (cyc <= e.due - 2);
                end
                if (in_exec) check("alu_drive", {alu_op, alu_a, alu_b}, {e.op, e.a, e.b});
                else         check("alu_quiet", {alu_op, alu_a, alu_b}, 69'd0);
                if (rsp_valid) begin
                    if (!in_rsp) begin
                        if (sb.size() == 0) begin
                            check("rsp_spurious_valid", rsp_valid, 1'b0);
                        end else begin
                            cur = sb.pop_front();
                            check("rsp_latency", cyc, cur.due);
                            in_rsp = 1'b1;
                        end
                    end
                    if (in_rsp) check("rsp_fields", {rsp_id, rsp_err, rsp_hi, rsp_lo},
                                      {cur.id, cur.err, cur.hi, cur.lo});
                    rsp_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                    if (rsp_ready && in_rsp) begin
                        in_rsp = 1'b0;
                        idle_from = cyc + 1;
                    end
                end else begin
                    if (sb.size() > 0 && cyc >= sb[0].due) begin
                        check("rsp_late_valid", rsp_valid, 1'b1);
                        void'(sb.pop_front());
                    end
                    rsp_ready = $urandom_range(0, 1);
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        stop_traffic = 1'b1;
        while ((req0_valid || req1_valid || sb.size() > 0 || in_rsp || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("drain_in_bound", (n < 3000), 1'b1);
        check("drain_idle", {busy, rsp_valid}, 2'b00);
    endtask

    initial begin : main
        int n;
        clr = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 5'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 5'd0;
        #1 clr = 1'b1;
        req0_valid = 1'b1; req0_op = T_ADD; req1_valid = 1'b1; req1_op = T_MUL;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {busy, rsp_valid, req0_ready, req1_ready, alu_op, alu_a, alu_b,
                                rsp_id, rsp_err, rsp_hi, rsp_lo}, 140'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #3 clr = 1'b0;

        dir_q0.push_back('{T_ADD, 32'd5, 32'd7});
        dir_q1.push_back('{T_MUL, 32'h10000, 32'h10000});
        dir_q0.push_back('{T_DIV, 32'd9, 32'd0});
        dir_q0.push_back('{5'b11111, 32'd3, 32'd4});
        started = 1'b1;

        repeat (1200) @(negedge clk);
        force_stall = 1'b1;
        repeat (12) @(negedge clk);
        force_stall = 1'b0;
        stop_traffic = 1'b0;
        repeat (1200) @(negedge clk);
        drain();

        // Abort an in-flight DIV with an asynchronous clear.
        dir_q0.push_back('{T_DIV, 32'd1000, 32'd7});
        n = 0;
        while (!(busy && alu_op == T_DIV) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("div_in_exec", alu_op, T_DIV);
        @(posedge clk); #3 clr = 1'b1;
        #1;
        check("clr_flush", {busy, rsp_valid, req0_ready, req1_ready, alu_op, alu_a, alu_b}, 73'd0);
        sb.delete(); in_rsp = 1'b0; idle_from = 0; last_served = 1;
        @(posedge clk); #3 clr = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("post_clr_quiet", {busy, rsp_valid}, 2'b00);

        stop_traffic = 1'b0;
        repeat (300) @(negedge clk);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
